tb_rst_seq_wdog: RTL
====================

Name: tb_rst_seq_wdog

Overview:
- Bench-side clock-domain controller that replaces the fixed one-shot reset pulse in the bench top.
- Takes one asynchronous active-low reset and produces NUM_CH staggered, synchronously released channel resets for the DUT and interfaces.
- Runs a test cycle counter and a kickable watchdog, and reports ready, done and timeout status to the test.
- Instantiated once per bench top, between clock/reset generation and the interface instances.

Parameters:
- NUM_CH, 4: number of channel reset outputs (1..16).
- HOLD_CYC, 8: cycles all channels stay in reset after internal reset release (>=1).
- STAGGER_CYC, 2: cycles between successive channel releases (>=0; 0 = release all together).
- TIMEOUT_CYC, 1000: watchdog limit in RUN without a kick (>=2).
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk  in  1  bench clock
- rst  in  1  asynchronous, active-low reset
- sw_rst_req  in  1  single-cycle request to restart the reset sequence
- kick  in  1  watchdog kick, sampled in RUN only
- test_done  in  1  level; test finished
- ch_rst_n  out  NUM_CH  per-channel active-low resets
- all_ready  out  1  all channels released, RUN entered
- timeout  out  1  sticky watchdog expiry flag
- cycle_cnt  out  CNT_W  cycles spent in RUN
- state_o  out  3  FSM state: HOLD=0, RELEASE=1, RUN=2, DONE=3, TOUT=4

Behaviour:
- rst low (asynchronous): state HOLD, ch_rst_n all 0, all_ready 0, timeout 0, cycle_cnt 0, internal counters 0. Takes effect immediately, without a clock edge.
- rst deassertion passes through a 2-flop synchronizer. E0 is the first rising edge at which the synchronized reset is high.
- HOLD: counts HOLD_CYC edges, then moves to RELEASE.
- RELEASE timing: ch_rst_n[i] rises at edge E0+HOLD_CYC+i*STAGGER_CYC. It stays high until the next reset source.
- RELEASE to RUN: at the edge after ch_rst_n[NUM_CH-1] rises, the FSM enters RUN and all_ready goes 1.
- RUN counters:
  - cycle_cnt increments once per edge and saturates at all-ones.
  - The watchdog counter increments once per edge and is cleared to 0 by kick.
- RUN exits:
  - Watchdog reaches TIMEOUT_CYC-1 without a kick: next edge is TOUT, timeout=1, ch_rst_n all 0, all_ready 0.
  - test_done=1: next edge is DONE, cycle_cnt frozen, all_ready stays 1, watchdog stopped.
- DONE is terminal until sw_rst_req or rst.
- TOUT without the macro is terminal until sw_rst_req or rst.
- sw_rst_req=1 in any state: next edge is HOLD. It drives ch_rst_n all 0, all_ready 0, clears timeout, cycle_cnt and watchdog, and restarts HOLD counting. E0 becomes that edge.
- Same-cycle priority: rst > sw_rst_req > test_done > kick > watchdog expiry. A kick on the expiry cycle prevents the timeout.
- kick and test_done outside RUN are ignored.
- STAGGER_CYC=0: all channels rise together at E0+HOLD_CYC.
- Reset mid-RELEASE: channels already released drop to 0 asynchronously on rst, or at the next edge on sw_rst_req.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TB_WDOG_AUTORST_EN.
- Defined: on watchdog expiry the FSM passes through TOUT for exactly one cycle, then automatically enters HOLD and re-runs the full sequence.
  - timeout stays 1 (sticky) across the restart and clears only on sw_rst_req or rst.
  - cycle_cnt clears on the restart.
- Not defined: TOUT is terminal as described under Behaviour.

Test Plan:
- Default parameters, rst low 3 cycles then high → ch_rst_n goes 0000 → 0001 at E0+8 → 0011 at E0+10 → 0111 at E0+12 → 1111 at E0+14; all_ready=1 and state_o=2 at E0+15.
- RUN, kick every 500 cycles for 3000 cycles, then test_done → no timeout; state_o=3; cycle_cnt frozen at the count on the test_done edge, constant for 100 more cycles.
- RUN, no kick → timeout=1 and ch_rst_n=0000 exactly 1000 edges after RUN entry. Same run with kick on cycle 999 → no timeout.
- sw_rst_req pulsed at E0+11 (ch_rst_n=0011) → next edge ch_rst_n=0000 and state_o=0. Release pattern repeats from that edge, with ch0 rising 8 edges later.
- rst asserted mid-RUN between clock edges → all outputs reach reset values before the next edge. The test_done+sw_rst_req same-cycle case enters HOLD, not DONE.
- TB_WDOG_AUTORST_EN defined, no kick → timeout=1, one TOUT cycle, then the HOLD/RELEASE pattern repeats; timeout remains 1 through the second RUN.

Source files
------------

// File: rtl/tb_rst_seq_wdog.sv
// Bench-side reset sequencer and watchdog.
// Turns one asynchronous active-low reset into NUM_CH staggered, synchronously
// released channel resets, then counts RUN cycles under a kickable watchdog.
// Optional feature macro: TB_WDOG_AUTORST_EN (watchdog expiry restarts the
// sequence after a single TOUT cycle instead of stopping there).
module tb_rst_seq_wdog #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned HOLD_CYC    = 8,
   parameter int unsigned STAGGER_CYC = 2,
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw_rst_req,
   input  logic              kick,
   input  logic              test_done,
   output logic [NUM_CH-1:0] ch_rst_n,
   output logic              all_ready,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [2:0]        state_o
);

   // Edge index (relative to E0) at which the last channel is released.
   localparam int unsigned LAST_REL = HOLD_CYC + (NUM_CH - 1) * STAGGER_CYC;
   localparam int unsigned SEQ_W    = $clog2(LAST_REL + 2);
   localparam int unsigned WD_W     = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_RELEASE = 3'd1,
      ST_RUN     = 3'd2,
      ST_DONE    = 3'd3,
      ST_TOUT    = 3'd4
   } state_t;

   logic [1:0]        r_sync;
   state_t            r_state;
   logic [SEQ_W-1:0]  r_seq;
   logic [NUM_CH-1:0] r_ch;
   logic              r_ready;
   logic              r_tout;
   logic [CNT_W-1:0]  r_cyc;
   logic [WD_W-1:0]   r_wdog;

   state_t            w_state_nxt;
   logic [SEQ_W-1:0]  w_seq_nxt;
   logic [NUM_CH-1:0] w_ch_nxt;
   logic              w_ready_nxt;
   logic              w_tout_nxt;
   logic [CNT_W-1:0]  w_cyc_nxt;
   logic [WD_W-1:0]   w_wdog_nxt;
   logic [CNT_W-1:0]  w_cyc_inc;

   // Two-flop synchronizer for the release edge of the external reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_sync <= 2'b00;
      else      r_sync <= {r_sync[0], 1'b1};
   end

   // Saturating RUN cycle counter increment.
   assign w_cyc_inc = (r_cyc == {CNT_W{1'b1}}) ? r_cyc : r_cyc + CNT_W'(1);

   // Next-state and next-output logic. r_seq holds the number of edges seen
   // since E0, so the edge that restarts the sequence (E0) loads it with 1.
   always_comb begin
      w_state_nxt = r_state;
      w_seq_nxt   = r_seq;
      w_ch_nxt    = r_ch;
      w_ready_nxt = r_ready;
      w_tout_nxt  = r_tout;
      w_cyc_nxt   = r_cyc;
      w_wdog_nxt  = r_wdog;

      if (r_sync[1]) begin
         if (sw_rst_req) begin
            w_state_nxt = ST_HOLD;
            w_seq_nxt   = SEQ_W'(1);
            w_ch_nxt    = '0;
            w_ready_nxt = 1'b0;
            w_tout_nxt  = 1'b0;
            w_cyc_nxt   = '0;
            w_wdog_nxt  = '0;
         end else begin
            case (r_state)
               ST_HOLD, ST_RELEASE: begin
                  w_seq_nxt = r_seq + SEQ_W'(1);
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     if (r_seq >= SEQ_W'(HOLD_CYC + i * STAGGER_CYC)) w_ch_nxt[i] = 1'b1;
                  end
                  if (r_seq == SEQ_W'(LAST_REL + 1)) begin
                     w_seq_nxt   = r_seq;
                     w_state_nxt = ST_RUN;
                     w_ready_nxt = 1'b1;
                  end else if (r_seq >= SEQ_W'(HOLD_CYC)) begin
                     w_state_nxt = ST_RELEASE;
                  end
               end
               ST_RUN: begin
                  // The test_done edge itself does not count: cycle_cnt freezes
                  // at the value it showed while test_done was sampled.
                  if (test_done) begin
                     w_state_nxt = ST_DONE;
                  end else if (kick) begin
                     w_wdog_nxt = '0;
                     w_cyc_nxt  = w_cyc_inc;
                  end else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                     w_state_nxt = ST_TOUT;
                     w_ch_nxt    = '0;
                     w_ready_nxt = 1'b0;
                     w_tout_nxt  = 1'b1;
                  end else begin
                     w_wdog_nxt = r_wdog + WD_W'(1);
                     w_cyc_nxt  = w_cyc_inc;
                  end
               end
               ST_TOUT: begin
`ifdef TB_WDOG_AUTORST_EN
                  // Automatic restart; timeout stays sticky.
                  w_state_nxt = ST_HOLD;
                  w_seq_nxt   = SEQ_W'(1);
                  w_ch_nxt    = '0;
                  w_ready_nxt = 1'b0;
                  w_cyc_nxt   = '0;
                  w_wdog_nxt  = '0;
`else
                  w_state_nxt = ST_TOUT;
`endif
               end
               default: begin
                  w_state_nxt = r_state;
               end
            endcase
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_HOLD;
         r_seq   <= '0;
         r_ch    <= '0;
         r_ready <= 1'b0;
         r_tout  <= 1'b0;
         r_cyc   <= '0;
         r_wdog  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_seq   <= w_seq_nxt;
         r_ch    <= w_ch_nxt;
         r_ready <= w_ready_nxt;
         r_tout  <= w_tout_nxt;
         r_cyc   <= w_cyc_nxt;
         r_wdog  <= w_wdog_nxt;
      end
   end

   assign ch_rst_n  = r_ch;
   assign all_ready = r_ready;
   assign timeout   = r_tout;
   assign cycle_cnt = r_cyc;
   assign state_o   = r_state;

endmodule
